// File: rtl/hack_clock_sequencer_pkg.sv
// hack_clock_sequencer_pkg: shared state encoding and limits for the Hack clock sequencer
//   state_t  HOLD/RUN/HALT/STEP, 2-bit encoding
//   DIV_MIN  smallest divide ratio a div_load may install
package hack_clock_sequencer_pkg;
    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2,
        STEP = 2'd3
    } state_t;
    localparam int DIV_MIN = 2;
endpackage

// File: rtl/hack_clock_sequencer_clk_en_divider.sv
// clk_en_divider: programmable free-running divider producing a one-clk Hack tick strobe
//   clk       board clock
//   reset     asynchronous active-high; cnt=0, div=DIV
//   div_load  one-clk pulse: install div_val if it is at least DIV_MIN
//   div_val   requested divide ratio
//   tick      high while cnt==div-1, masked on an accepted load edge
module clk_en_divider
    import hack_clock_sequencer_pkg::*;
#(
    parameter int DIV   = 3,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_val,
    output logic             tick
);
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div;
    logic             wrap;
    logic             load_ok;

    assign wrap    = cnt == div - 1'b1;
    assign load_ok = div_load && div_val >= DIV_W'(DIV_MIN);
    // An accepted load restarts the count, so the tick that coincides with it is dropped.
    assign tick    = wrap && !load_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            div <= DIV_W'(DIV);
        end else if (load_ok) begin
            cnt <= '0;
            div <= div_val;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/hack_clock_sequencer.sv
// hack_clock_sequencer: run/halt/single-step controller issuing Hack clock enables
//   clk         board clock
//   reset       asynchronous active-high; returns everything to the reset-hold state
//   run         level: 1 free-run, 0 halt (sampled on ticks)
//   step        one-clk pulse: one Hack tick while halted
//   sreset      one-clk pulse: restart the reset-hold sequence
//   div_load    one-clk pulse: load div_val as divide ratio
//   div_val     new divide ratio
//   hack_en     registered one-clk Hack clock enable
//   hack_reset  registered reset to the Hack CPU
//   halted      registered, 1 while in HALT
module hack_clock_sequencer
    import hack_clock_sequencer_pkg::*;
#(
    parameter int DIV       = 3,
    parameter int DIV_W     = 8,
    parameter int RST_TICKS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic             sreset,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_val,
    output logic             hack_en,
    output logic             hack_reset,
    output logic             halted
);
    logic       tick;
    state_t     state;
    state_t     state_next;
    logic [7:0] hold_cnt;
    logic [7:0] hold_cnt_next;
    logic       step_pend;
    logic       step_pend_next;

    clk_en_divider #(
        .DIV   (DIV),
        .DIV_W (DIV_W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .div_load (div_load),
        .div_val  (div_val),
        .tick     (tick)
    );

    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        if (sreset) begin
            state_next    = HOLD;
            hold_cnt_next = '0;
        end else if (tick) begin
            case (state)
                HOLD: begin
                    if (hold_cnt == 8'(RST_TICKS - 1)) begin
                        hold_cnt_next = '0;
                        state_next    = run ? RUN : HALT;
                    end else begin
                        hold_cnt_next = hold_cnt + 8'd1;
                    end
                end
                RUN:     state_next = run ? RUN : HALT;
                HALT:    state_next = run ? RUN : (step_pend ? STEP : HALT);
                STEP:    state_next = HALT;
                default: state_next = HOLD;
            endcase
        end
        // Pending step is consumed whenever HALT is left; a pulse on that same edge is dropped.
        step_pend_next = (sreset || (state == HALT && state_next != HALT)) ? 1'b0 :
                         (state == HALT && step) ? 1'b1 : step_pend;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= HOLD;
            hold_cnt   <= '0;
            step_pend  <= 1'b0;
            hack_en    <= 1'b0;
            hack_reset <= 1'b1;
            halted     <= 1'b0;
        end else begin
            state      <= state_next;
            hold_cnt   <= hold_cnt_next;
            step_pend  <= step_pend_next;
            hack_en    <= tick && state != HALT;
            // Held through the enable of the last hold tick so the CPU sees RST_TICKS enables in reset.
            hack_reset <= state_next == HOLD || state == HOLD;
            halted     <= state_next == HALT;
        end
    end
endmodule

// File: tb/tb_hack_clock_sequencer.sv
// tb_hack_clock_sequencer: directed self-checking bench for hack_clock_sequencer
module tb_hack_clock_sequencer;
    logic       clk;
    logic       reset;
    logic       run;
    logic       step;
    logic       sreset;
    logic       div_load;
    logic [7:0] div_val;
    logic       hack_en;
    logic       hack_reset;
    logic       halted;
    int         n_cmp;
    int         n_bad;

    hack_clock_sequencer #(
        .DIV       (3),
        .DIV_W     (8),
        .RST_TICKS (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .step       (step),
        .sreset     (sreset),
        .div_load   (div_load),
        .div_val    (div_val),
        .hack_en    (hack_en),
        .hack_reset (hack_reset),
        .halted     (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    // Advance n clks, checking hack_en is high exactly on clk first, first+spacing, ...
    task automatic expect_en(input string tag, input int n, input int first, input int spacing);
        for (int i = 1; i <= n; i++) begin
            clk1();
            chk($sformatf("%s[%0d]", tag, i), 32'(hack_en),
                32'(first > 0 && i >= first && (i - first) % spacing == 0));
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        reset    = 1'b1;
        run      = 1'b1;
        step     = 1'b0;
        sreset   = 1'b0;
        div_load = 1'b0;
        div_val  = 8'd0;
        repeat (5) clk1();
        chk("rst_en", 32'(hack_en), 0);
        chk("rst_hr", 32'(hack_reset), 1);
        chk("rst_halted", 32'(halted), 0);
        reset = 1'b0;

        expect_en("boot", 12, 3, 3);
        chk("boot_hr4", 32'(hack_reset), 1);
        clk1();
        chk("boot_hr_drop", 32'(hack_reset), 0);
        chk("boot_en13", 32'(hack_en), 0);
        expect_en("run", 5, 2, 3);
        chk("run_hr", 32'(hack_reset), 0);

        expect_en("pre_halt", 2, 0, 1);
        run = 1'b0;
        clk1();
        chk("halt_last_en", 32'(hack_en), 1);
        chk("halt_flag", 32'(halted), 1);
        expect_en("halt", 30, 0, 1);
        chk("halt_hold", 32'(halted), 1);

        step = 1'b1;
        clk1();
        step = 1'b0;
        step = 1'b1;
        clk1();
        step = 1'b0;
        clk1();
        chk("step_enter_en", 32'(hack_en), 0);
        chk("step_enter_halted", 32'(halted), 0);
        expect_en("step", 3, 3, 3);
        chk("step_back_halted", 32'(halted), 1);
        expect_en("step_idle", 24, 0, 1);

        expect_en("pre_tstep", 2, 0, 1);
        step = 1'b1;
        clk1();
        step = 1'b0;
        chk("tstep_en", 32'(hack_en), 0);
        chk("tstep_halted", 32'(halted), 1);
        expect_en("tstep_wait", 3, 0, 1);
        chk("tstep_in_step", 32'(halted), 0);
        expect_en("tstep", 3, 3, 3);
        chk("tstep_back", 32'(halted), 1);

        run    = 1'b1;
        sreset = 1'b1;
        clk1();
        sreset = 1'b0;
        chk("rehold_hr", 32'(hack_reset), 1);
        chk("rehold_halted", 32'(halted), 0);
        expect_en("rehold", 11, 2, 3);
        chk("rehold_hr4", 32'(hack_reset), 1);
        clk1();
        chk("rehold_hr_drop", 32'(hack_reset), 0);
        step = 1'b1;
        clk1();
        step = 1'b0;
        chk("runstep_en0", 32'(hack_en), 0);
        expect_en("runstep", 7, 1, 3);
        chk("runstep_halted", 32'(halted), 0);

        div_load = 1'b1;
        div_val  = 8'd5;
        clk1();
        div_load = 1'b0;
        chk("div5_load_en", 32'(hack_en), 0);
        expect_en("div5", 15, 5, 5);
        div_load = 1'b1;
        div_val  = 8'd1;
        clk1();
        div_load = 1'b0;
        chk("div1_load_en", 32'(hack_en), 0);
        expect_en("div1", 9, 4, 5);

        sreset = 1'b1;
        clk1();
        sreset = 1'b0;
        chk("sreset_hr", 32'(hack_reset), 1);
        chk("sreset_en", 32'(hack_en), 0);
        expect_en("shold", 19, 4, 5);
        chk("shold_hr4", 32'(hack_reset), 1);
        clk1();
        chk("shold_hr_drop", 32'(hack_reset), 0);
        chk("shold_en", 32'(hack_en), 0);
        expect_en("sresume", 4, 4, 5);

        #2;
        reset = 1'b1;
        #1;
        chk("async_en", 32'(hack_en), 0);
        chk("async_hr", 32'(hack_reset), 1);
        chk("async_halted", 32'(halted), 0);
        repeat (3) clk1();
        reset = 1'b0;
        expect_en("reboot", 6, 3, 3);
        chk("reboot_hr", 32'(hack_reset), 1);
        chk("reboot_halted", 32'(halted), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
